rv32_dmem_responder: RTL

RV32_DMEM_RESPONDER -- requirements
Module: rv32_dmem_responder

---
 rtl/rv32_dmem_responder_if.sv | 21 ++
 rtl/rv32_dmem_responder.sv | 87 ++++++++
 2 files changed

// File: rtl/rv32_dmem_responder_if.sv
// rv32_dmem_responder_if: request/response bus between a load/store initiator and the data memory responder.
interface rv32_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: single-outstanding word memory with byte-lane stores, fixed wait latency and fault reporting.
module rv32_dmem_responder #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  ncpurst,
    rv32_dmem_responder_if.slave bus
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   mem [MEM_DEPTH];
    logic          accept, go_resp, cur_we, fault;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_be;
    logic [AW-1:0] idx;

    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign accept        = state == IDLE && bus.req_valid;
    // With zero wait cycles the access completes on the accept edge, before the holding registers load
    assign cur_we    = state == IDLE ? bus.req_we    : we_q;
    assign cur_addr  = state == IDLE ? bus.req_addr  : addr_q;
    assign cur_wdata = state == IDLE ? bus.req_wdata : wdata_q;
    assign cur_be    = state == IDLE ? bus.req_be    : be_q;
    assign idx       = cur_addr[AW+1:2];
    assign fault     = (|cur_addr[1:0]) || (cur_addr[31:2] >= 30'(MEM_DEPTH)) || (cur_we && cur_be == 4'b0000);
    assign go_resp   = state_nx == RESP && state != RESP;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_nx   = CNT_INIT;
            end
            WAIT: begin
                cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                state_nx = cnt == 4'd0 ? RESP : WAIT;
            end
            RESP: state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ncpurst) begin
        if (!ncpurst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            be_q          <= 4'd0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (go_resp) begin
                bus.rsp_rdata <= (fault || cur_we) ? 32'd0 : mem[idx];
                bus.rsp_err   <= fault;
            end
        end
    end

    // Memory is never reset; the reset gate stops a zero-wait accept from writing while held in reset
    always_ff @(posedge clk) begin
        if (go_resp && ncpurst && cur_we && !fault)
            for (int i = 0; i < 4; i++)
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
endmodule
